// File: rtl/mpr121_target_model.sv
// mpr121_target_model
// I2C target that emulates the MPR121 register map, used as the far end of the
// bus for the MPR121 initiator controller in simulation and loopback builds.
//
// Parameters:
//   TARGET_ADDR      7-bit I2C address answered (default 7'h5A)
// Ports:
//   clk_in           system clock (>= 8 cycles per SCL half-period)
//   rst_in           synchronous active-high reset
//   scl_in           bus SCL, asynchronous to clk_in
//   sda              bus SDA, open-drain (driven 0 or released)
//   touch_status_in  live electrode status, [7:0] -> reg 0x00, [11:8] -> reg 0x01
//   ecr_out          current ECR (reg 0x5E)
//   wr_valid_out     one-cycle pulse per stored data-byte write
//   wr_addr_out      register written, valid with wr_valid_out
//   wr_data_out      byte written, valid with wr_valid_out
//   busy_out         high from address match until STOP or non-matching START
// Build option:
//   MPR121_TARGET_AUTOINC_EN  pointer auto-increments after each data byte;
//                             a 0x00/0x01 burst read shares one status snapshot.
`timescale 1ns/1ps
module mpr121_target_model #(
  parameter logic [6:0] TARGET_ADDR = 7'h5A
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        scl_in,
  inout  wire         sda,
  input  logic [11:0] touch_status_in,
  output logic [7:0]  ecr_out,
  output logic        wr_valid_out,
  output logic [7:0]  wr_addr_out,
  output logic [7:0]  wr_data_out,
  output logic        busy_out
);

  localparam int NUM_THR = 26;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD, S_CMD_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_WAIT_STOP
  } state_t;

  state_t      state;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic        sda_oe;
  logic [7:0]  shift_reg;
  logic [3:0]  bit_cnt;
  logic [7:0]  ptr;
  logic [7:0]  tx_byte;
  logic        rw_bit;
  logic [7:0]  thr [NUM_THR];
  logic [7:0]  rd_val;
  logic [7:0]  rx_next;
  logic [4:0]  thr_idx;
  logic        scl_rise, scl_fall, start_det, stop_det, load_rd;
`ifdef MPR121_TARGET_AUTOINC_EN
  logic [3:0]  snap_hi;
  logic        snap_vld;
`endif

  assign sda = sda_oe ? 1'b0 : 1'bz;

  function automatic logic is_thr(input logic [7:0] a);
    return (a >= 8'h41) && (a <= 8'h5A);
  endfunction

  // Stage p0/p1: two-flop synchronizers; stage p2: edge-detect history
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      scl_p0 <= scl_in;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign rx_next   = {shift_reg[6:0], sda_p1};
  assign thr_idx   = 5'(ptr - 8'h41);

  // A read byte is loaded at the fall ending the address ACK or an initiator ACK
  assign load_rd = scl_fall && !start_det && !stop_det &&
                   (((state == S_ADDR_ACK) && rw_bit) ||
                    ((state == S_MACK) && (bit_cnt == 4'd1)));

  always_comb begin
    rd_val = 8'h00;
    if (ptr == 8'h00)
      rd_val = touch_status_in[7:0];
    else if (ptr == 8'h01) begin
`ifdef MPR121_TARGET_AUTOINC_EN
      rd_val = snap_vld ? {4'h0, snap_hi} : {4'h0, touch_status_in[11:8]};
`else
      rd_val = {4'h0, touch_status_in[11:8]};
`endif
    end else if (ptr == 8'h5D)
      rd_val = 8'h24;
    else if (ptr == 8'h5E)
      rd_val = ecr_out;
    else if (is_thr(ptr))
      rd_val = thr[thr_idx];
  end

  // Protocol FSM, register file and write strobe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      sda_oe       <= 1'b0;
      shift_reg    <= 8'h00;
      bit_cnt      <= 4'd0;
      ptr          <= 8'h00;
      tx_byte      <= 8'h00;
      rw_bit       <= 1'b0;
      ecr_out      <= 8'h00;
      wr_valid_out <= 1'b0;
      wr_addr_out  <= 8'h00;
      wr_data_out  <= 8'h00;
      busy_out     <= 1'b0;
      for (int i = 0; i < NUM_THR; i++) thr[i] <= 8'h00;
`ifdef MPR121_TARGET_AUTOINC_EN
      snap_hi      <= 4'h0;
      snap_vld     <= 1'b0;
`endif
    end else begin
      wr_valid_out <= 1'b0;
      if (stop_det) begin
        state    <= S_IDLE;
        sda_oe   <= 1'b0;
        busy_out <= 1'b0;
      end else if (start_det) begin
        state   <= S_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
`ifdef MPR121_TARGET_AUTOINC_EN
        snap_vld <= 1'b0;
`endif
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shift_reg <= rx_next;
              bit_cnt   <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shift_reg[7:1] == TARGET_ADDR) begin
                sda_oe   <= 1'b1;
                busy_out <= 1'b1;
                rw_bit   <= shift_reg[0];
                state    <= S_ADDR_ACK;
              end else begin
                busy_out <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw_bit) state <= S_RDATA;
              else begin
                sda_oe <= 1'b0;
                state  <= S_CMD;
              end
            end
          end
          S_CMD: begin
            if (scl_rise) begin
              shift_reg <= rx_next;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) ptr <= rx_next;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= S_CMD_ACK;
            end
          end
          S_WDATA: begin
            if (scl_rise) begin
              shift_reg <= rx_next;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                // Read-only and unmapped targets are ACKed but not stored
                if (is_thr(ptr) || ptr == 8'h5E) begin
                  wr_valid_out <= 1'b1;
                  wr_addr_out  <= ptr;
                  wr_data_out  <= rx_next;
                  if (ptr == 8'h5E) ecr_out <= rx_next;
                  else              thr[thr_idx] <= rx_next;
                end
`ifdef MPR121_TARGET_AUTOINC_EN
                ptr <= ptr + 8'd1;
`endif
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= S_WDATA_ACK;
            end
          end
          S_CMD_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_MACK;
              end else
                sda_oe <= ~tx_byte[3'd7 - bit_cnt[2:0]];
            end
          end
          S_MACK: begin
            // bit_cnt==1 marks an initiator ACK seen on this bit
            if (scl_rise) begin
              if (sda_p1) state <= S_WAIT_STOP;
              else        bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= 4'd0;
              state   <= S_RDATA;
            end
          end
          default: ;
        endcase
        if (load_rd) begin
          tx_byte <= rd_val;
          sda_oe  <= ~rd_val[7];
`ifdef MPR121_TARGET_AUTOINC_EN
          ptr <= ptr + 8'd1;
          if (ptr == 8'h00) begin
            snap_hi  <= touch_status_in[11:8];
            snap_vld <= 1'b1;
          end else
            snap_vld <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
